// File: rtl/exp_pipe_pkg.sv
// Shared constants for the FP exponent pipeline: spec flag bit positions and
// operation select encoding.
package exp_pipe_pkg;

    localparam int unsigned SPEC_W = 4;

    // Bit positions inside the spec vector {infA, infB, zA, zB}
    localparam int unsigned INF_A = 3;
    localparam int unsigned INF_B = 2;
    localparam int unsigned Z_A   = 1;
    localparam int unsigned Z_B   = 0;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/exp_pipe_stage.sv
// Generic valid/ready register slice. The payload loads only on a real transfer,
// so it holds steady while the consumer stalls.
module exp_pipe_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready_c,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic advance_c;

    // Slice can take new data when it is empty or its content is leaving
    assign advance_c  = !out_valid || out_ready;
    assign in_ready_c = advance_c;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance_c) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/exp_pipe_unit.sv
// Two-stage pipelined exponent unit for FP multiply/divide: computes the biased
// result exponent, range flags and operand special-class flags.
module exp_pipe_unit
    import exp_pipe_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned BIAS  = 2**(EXP_W-1)-1,
    parameter int unsigned OUT_W = EXP_W+2
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  eA,
    input  logic [EXP_W-1:0]  eB,
    input  logic              sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  e,
    output logic [EXP_W-1:0]  e_sat,
    output logic              ovf,
    output logic              unf,
    output logic [SPEC_W-1:0] spec
);

    localparam int unsigned S1_W = OUT_W + SPEC_W;
    localparam int unsigned S2_W = OUT_W + SPEC_W + EXP_W + 2;
    localparam logic [OUT_W-1:0] MAX_E  = OUT_W'((2**EXP_W) - 1);
    localparam logic [OUT_W-1:0] BIAS_X = OUT_W'(BIAS);

    logic [OUT_W-1:0]  ea_x;
    logic [OUT_W-1:0]  eb_x;
    logic [OUT_W-1:0]  raw_c;
    logic [SPEC_W-1:0] spec_c;

    logic              s1_in_ready_c;
    logic              s1_valid;
    logic [S1_W-1:0]   s1_data;
    logic [OUT_W-1:0]  s1_raw;
    logic [SPEC_W-1:0] s1_spec;

    logic              s2_in_ready_c;
    logic [S2_W-1:0]   s2_data;
    logic              ovf_c;
    logic              unf_c;
    logic [EXP_W-1:0]  e_sat_c;

    assign ea_x = OUT_W'(eA);
    assign eb_x = OUT_W'(eB);

    // Raw biased exponent and operand classification for stage 1
    always_comb begin
        raw_c  = ea_x + eb_x - BIAS_X;
        spec_c = '0;
        if (sel == OP_DIV) begin
            raw_c = ea_x - eb_x + BIAS_X;
        end
        spec_c[INF_A] = &eA;
        spec_c[INF_B] = &eB;
        spec_c[Z_A]   = ~|eA;
        spec_c[Z_B]   = ~|eB;
    end

    exp_pipe_stage #(.W(S1_W)) u_s1 (
        .clk        (clk),
        .arst       (arst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready_c (s1_in_ready_c),
        .in_data    ({raw_c, spec_c}),
        .out_valid  (s1_valid),
        .out_ready  (s2_in_ready_c),
        .out_data   (s1_data)
    );

    assign in_ready = s1_in_ready_c;
    assign s1_raw   = s1_data[S1_W-1 -: OUT_W];
    assign s1_spec  = s1_data[SPEC_W-1:0];

    // Range flags and saturated field value for stage 2
    always_comb begin
        ovf_c   = ($signed(s1_raw) >= $signed(MAX_E));
        unf_c   = s1_raw[OUT_W-1] || (s1_raw == '0);
        e_sat_c = s1_raw[EXP_W-1:0];
        if (ovf_c) begin
            e_sat_c = '1;
        end else if (unf_c) begin
            e_sat_c = '0;
        end
    end

    exp_pipe_stage #(.W(S2_W)) u_s2 (
        .clk        (clk),
        .arst       (arst),
        .flush      (flush),
        .in_valid   (s1_valid),
        .in_ready_c (s2_in_ready_c),
        .in_data    ({s1_raw, s1_spec, e_sat_c, ovf_c, unf_c}),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (s2_data)
    );

    assign e     = s2_data[S2_W-1 -: OUT_W];
    assign spec  = s2_data[EXP_W+2+SPEC_W-1 -: SPEC_W];
    assign e_sat = s2_data[EXP_W+1 -: EXP_W];
    assign ovf   = s2_data[1];
    assign unf   = s2_data[0];

endmodule

// File: tb/tb_exp_pipe_unit.sv
// Self-checking bench for exp_pipe_unit: directed vectors plus randomized
// traffic on EXP_W=8 and EXP_W=11 instances against an integer reference model.
`timescale 1ns/1ps
module tb_exp_pipe_unit;

    typedef struct {
        int         raw;
        int         sat;
        logic       ovf;
        logic       unf;
        logic [3:0] spec;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst, flush, in_valid, sel, out_ready;
    logic [7:0]  ea8, eb8;
    logic [10:0] ea11, eb11;
    logic        ir8, ov8, ovf8, unf8;
    logic [9:0]  e8;
    logic [7:0]  es8;
    logic [3:0]  sp8;
    logic        ir11, ov11, ovf11, unf11;
    logic [12:0] e11;
    logic [10:0] es11;
    logic [3:0]  sp11;

    int nchecks = 0;
    int nerrors = 0;

    exp_pipe_unit #(.EXP_W(8)) dut8 (
        .clk(clk), .arst(arst), .flush(flush), .in_valid(in_valid), .in_ready(ir8),
        .eA(ea8), .eB(eb8), .sel(sel), .out_valid(ov8), .out_ready(out_ready),
        .e(e8), .e_sat(es8), .ovf(ovf8), .unf(unf8), .spec(sp8)
    );

    exp_pipe_unit #(.EXP_W(11)) dut11 (
        .clk(clk), .arst(arst), .flush(flush), .in_valid(in_valid), .in_ready(ir11),
        .eA(ea11), .eB(eb11), .sel(sel), .out_valid(ov11), .out_ready(out_ready),
        .e(e11), .e_sat(es11), .ovf(ovf11), .unf(unf11), .spec(sp11)
    );

    // Reference: exact integer arithmetic straight from the operation definition
    function automatic res_t model(int a, int b, logic s, int w);
        res_t r;
        int bias = (1 << (w-1)) - 1;
        int top  = (1 << w) - 1;
        r.raw  = s ? (a - b + bias) : (a + b - bias);
        r.ovf  = (r.raw >= top);
        r.unf  = (r.raw <= 0);
        r.sat  = r.ovf ? top : (r.unf ? 0 : r.raw);
        r.spec = {a == top, b == top, a == 0, b == 0};
        return r;
    endfunction

    function automatic res_t got8();
        res_t r;
        r.raw = int'($signed(e8)); r.sat = int'(es8);
        r.ovf = ovf8; r.unf = unf8; r.spec = sp8;
        return r;
    endfunction

    function automatic res_t got11();
        res_t r;
        r.raw = int'($signed(e11)); r.sat = int'(es11);
        r.ovf = ovf11; r.unf = unf11; r.spec = sp11;
        return r;
    endfunction

    function automatic bit res_eq(res_t a, res_t b);
        return (a.raw == b.raw) && (a.sat == b.sat) && (a.ovf === b.ovf)
            && (a.unf === b.unf) && (a.spec === b.spec);
    endfunction

    function automatic string fmt(res_t r);
        return $sformatf("raw=%0d sat=%0d ovf=%0b unf=%0b spec=%b", r.raw, r.sat, r.ovf, r.unf, r.spec);
    endfunction

    function automatic int pick(int w);
        int top = (1 << w) - 1;
        case ($urandom_range(0, 7))
            0: return 0;
            1: return top;
            default: return int'($urandom_range(0, top));
        endcase
    endfunction

    task automatic test_reset();
        arst = 1'b0; flush = 1'b0; in_valid = 1'b0; sel = 1'b0; out_ready = 1'b1;
        ea8 = '0; eb8 = '0; ea11 = '0; eb11 = '0;
        #12;
        nchecks++;
        if ({ov8, ov11, e8, es8, ovf8, unf8, sp8} !== '0) begin
            nerrors++;
            $display("FAIL reset_state: got ov8=%b ov11=%b e=%h e_sat=%h ovf=%b unf=%b spec=%b, expected all 0",
                     ov8, ov11, e8, es8, ovf8, unf8, sp8);
        end
        @(negedge clk); arst = 1'b1;
        @(negedge clk); #1;
        nchecks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            nerrors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1/0", ir8, ov8);
        end
    endtask

    task automatic test_arith();
        int   va[11] = '{130, 127,   0, 200,  10, 127, 128,   1,   0, 255, 255};
        int   vb[11] = '{127, 127, 255, 200,  20, 254, 254, 127, 127, 255,   0};
        logic vs[11] = '{0,   1,   1,   0,   0,   0,   0,   0,   0,   0,   1};
        res_t xv[11];
        res_t g;
        xv[0]  = '{130, 130, 1'b0, 1'b0, 4'b0000};
        xv[1]  = '{127, 127, 1'b0, 1'b0, 4'b0000};
        xv[2]  = '{-128,  0, 1'b0, 1'b1, 4'b0110};
        xv[3]  = '{273, 255, 1'b1, 1'b0, 4'b0000};
        xv[4]  = '{-97,   0, 1'b0, 1'b1, 4'b0000};
        xv[5]  = '{254, 254, 1'b0, 1'b0, 4'b0000};
        xv[6]  = '{255, 255, 1'b1, 1'b0, 4'b0000};
        xv[7]  = '{1,     1, 1'b0, 1'b0, 4'b0000};
        xv[8]  = '{0,     0, 1'b0, 1'b1, 4'b0010};
        xv[9]  = '{383, 255, 1'b1, 1'b0, 4'b1100};
        xv[10] = '{382, 255, 1'b1, 1'b0, 4'b1001};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1;
            ea8 = 8'(va[i]); eb8 = 8'(vb[i]); sel = vs[i];
            @(negedge clk);
            in_valid = 1'b0; #1;
            nchecks++;
            if (ov8 !== 1'b0) begin
                nerrors++;
                $display("FAIL arith_latency[%0d]: got out_valid=%b one cycle after accept, expected 0", i, ov8);
            end
            @(negedge clk); #1;
            g = got8();
            nchecks++;
            if (ov8 !== 1'b1 || !res_eq(g, xv[i])) begin
                nerrors++;
                $display("FAIL arith[%0d]: got valid=%b %s, expected valid=1 %s", i, ov8, fmt(g), fmt(xv[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int   a[6], b[6];
        logic s[6];
        res_t x, g;
        for (int i = 0; i < 6; i++) begin
            a[i] = pick(8); b[i] = pick(8); s[i] = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (k < 6);
            if (k < 6) begin
                ea8 = 8'(a[k]); eb8 = 8'(b[k]); sel = s[k];
            end
            #1;
            if (k < 6) begin
                nchecks++;
                if (ir8 !== 1'b1) begin
                    nerrors++;
                    $display("FAIL b2b_ready[%0d]: got in_ready=%b, expected 1", k, ir8);
                end
            end
            if (k >= 2) begin
                x = model(a[k-2], b[k-2], s[k-2], 8);
                g = got8();
                nchecks++;
                if (ov8 !== 1'b1 || !res_eq(g, x)) begin
                    nerrors++;
                    $display("FAIL b2b_result[%0d]: got valid=%b %s, expected valid=1 %s", k-2, ov8, fmt(g), fmt(x));
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        res_t q[$];
        res_t x, g;
        int   a[4], b[4];
        logic s[4];
        int   sent = 0;
        int   popped = 0;
        logic [9:0] held = '0;
        for (int i = 0; i < 4; i++) begin
            a[i] = pick(8); b[i] = pick(8); s[i] = 1'($urandom_range(0, 1));
        end
        for (int cyc = 0; cyc < 30 && popped < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            in_valid = (sent < 4);
            if (sent < 4) begin
                ea8 = 8'(a[sent]); eb8 = 8'(b[sent]); sel = s[sent];
            end
            #1;
            if (cyc == 2 || cyc == 3) begin
                nchecks++;
                if (ir8 !== 1'b0 || sent != 2) begin
                    nerrors++;
                    $display("FAIL bp_stall[%0d]: got in_ready=%b accepted=%0d, expected 0 and 2", cyc, ir8, sent);
                end
            end
            if (cyc == 2) held = e8;
            if (cyc == 3 || cyc == 4) begin
                nchecks++;
                if (ov8 !== 1'b1 || e8 !== held) begin
                    nerrors++;
                    $display("FAIL bp_hold[%0d]: got valid=%b e=%h, expected valid=1 e=%h", cyc, ov8, e8, held);
                end
            end
            if (cyc == 4) begin
                nchecks++;
                if (ir8 !== 1'b1) begin
                    nerrors++;
                    $display("FAIL bp_no_bubble: got in_ready=%b with full pipe and out_ready=1, expected 1", ir8);
                end
            end
            if (in_valid && ir8) begin
                q.push_back(model(a[sent], b[sent], s[sent], 8));
                sent++;
            end
            if (ov8 && out_ready) begin
                nchecks++;
                g = got8();
                if (q.size() == 0) begin
                    nerrors++;
                    $display("FAIL bp_order: got unexpected result %s, expected none", fmt(g));
                end else begin
                    x = q.pop_front();
                    if (!res_eq(g, x)) begin
                        nerrors++;
                        $display("FAIL bp_order[%0d]: got %s, expected %s", popped, fmt(g), fmt(x));
                    end
                end
                popped++;
            end
        end
        in_valid = 1'b0;
        nchecks++;
        if (popped != 4 || q.size() != 0) begin
            nerrors++;
            $display("FAIL bp_count: got %0d results (%0d pending), expected 4 (0)", popped, q.size());
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; ea8 = 8'd130; eb8 = 8'd127; sel = 1'b0;
        @(negedge clk);
        ea8 = 8'd100; eb8 = 8'd100;
        @(negedge clk); #1;
        nchecks++;
        if (ov8 !== 1'b1 || ir8 !== 1'b0) begin
            nerrors++;
            $display("FAIL flush_full: got out_valid=%b in_ready=%b, expected 1/0", ov8, ir8);
        end
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; ea8 = 8'd50; eb8 = 8'd60;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            nchecks++;
            if (ov8 !== 1'b0) begin
                nerrors++;
                $display("FAIL flush_clear[%0d]: got out_valid=%b e=%h, expected 0", k, ov8, e8);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b1; ea8 = 8'd200; eb8 = 8'd200; sel = 1'b0;
        @(negedge clk); ea8 = 8'd255; eb8 = 8'd0;
        @(negedge clk); #1;
        nchecks++;
        if (ov8 !== 1'b1 || ovf8 !== 1'b1) begin
            nerrors++;
            $display("FAIL rst_mid_pre: got out_valid=%b ovf=%b, expected 1/1", ov8, ovf8);
        end
        arst = 1'b0; in_valid = 1'b0;
        #1;
        nchecks++;
        if ({ov8, e8, es8, ovf8, unf8, sp8} !== '0 || ir8 !== 1'b1) begin
            nerrors++;
            $display("FAIL rst_mid: got valid=%b e=%h e_sat=%h ovf=%b unf=%b spec=%b in_ready=%b, expected zeros and in_ready=1",
                     ov8, e8, es8, ovf8, unf8, sp8, ir8);
        end
        @(negedge clk); arst = 1'b1;
        @(negedge clk); #1;
        nchecks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            nerrors++;
            $display("FAIL rst_mid_release: got in_ready=%b out_valid=%b, expected 1/0", ir8, ov8);
        end
    endtask

    task automatic test_random();
        res_t q8[$], q11[$];
        res_t x, g;
        logic       hold_v = 1'b0;
        logic [9:0] hold_e = '0;
        int         errs_before = nerrors;
        for (int cyc = 0; cyc < 2030; cyc++) begin
            @(negedge clk);
            in_valid  = (cyc < 2000) && ($urandom_range(0, 3) != 0);
            out_ready = (cyc >= 2000) || ($urandom_range(0, 3) != 0);
            sel  = 1'($urandom_range(0, 1));
            ea8  = 8'(pick(8));   eb8  = 8'(pick(8));
            ea11 = 11'(pick(11)); eb11 = 11'(pick(11));
            #1;
            if (hold_v) begin
                nchecks++;
                if (ov8 !== 1'b1 || e8 !== hold_e) begin
                    nerrors++;
                    $display("FAIL rnd_hold[%0d]: got valid=%b e=%h, expected valid=1 e=%h", cyc, ov8, e8, hold_e);
                end
            end
            hold_v = ov8 && !out_ready;
            hold_e = e8;
            if (in_valid && ir8)  q8.push_back(model(int'(ea8), int'(eb8), sel, 8));
            if (in_valid && ir11) q11.push_back(model(int'(ea11), int'(eb11), sel, 11));
            if (ov8 && out_ready) begin
                nchecks++;
                g = got8();
                if (q8.size() == 0) begin
                    nerrors++;
                    $display("FAIL rnd8[%0d]: got unexpected %s, expected no result", cyc, fmt(g));
                end else begin
                    x = q8.pop_front();
                    if (!res_eq(g, x)) begin
                        nerrors++;
                        $display("FAIL rnd8[%0d]: got %s, expected %s", cyc, fmt(g), fmt(x));
                    end
                end
            end
            if (ov11 && out_ready) begin
                nchecks++;
                g = got11();
                if (q11.size() == 0) begin
                    nerrors++;
                    $display("FAIL rnd11[%0d]: got unexpected %s, expected no result", cyc, fmt(g));
                end else begin
                    x = q11.pop_front();
                    if (!res_eq(g, x)) begin
                        nerrors++;
                        $display("FAIL rnd11[%0d]: got %s, expected %s", cyc, fmt(g), fmt(x));
                    end
                end
            end
            if (nerrors - errs_before > 20) break;
        end
        in_valid = 1'b0;
        nchecks++;
        if (q8.size() != 0 || q11.size() != 0) begin
            nerrors++;
            $display("FAIL rnd_drain: got %0d/%0d results still pending, expected 0/0", q8.size(), q11.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by 1ms, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
